// File: rtl/fetch_pc_control_pkg.sv
// Shared fetch-stage constants: FSM encodings, halt instruction word and
// the sequential PC increment, plus a small state-decoding helper.
package fetch_pc_control_pkg;

    // FSM encodings, visible to the debug unit through o_state
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    // Instruction encoding that stops fetch
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_INC = 4;

    // A fetch cycle is any cycle spent in RUN or STEP
    function automatic logic is_fetch_state(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/fetch_pc_control_if.sv
// Bundle between the fetch PC controller and its surroundings (debug unit,
// hazard unit, branch/jump resolution and instruction memory).
interface fetch_pc_control_if #(
    parameter int NBITS = 32
);
    logic             i_run;
    logic             i_step;
    logic             i_restart;
    logic             i_stall;
    logic             i_branch;
    logic [NBITS-1:0] i_branch_target;
    logic             i_jump;
    logic [NBITS-1:0] i_jump_target;
    logic [NBITS-1:0] i_instruction;
    logic [NBITS-1:0] o_pc;
    logic [NBITS-1:0] o_pc_plus4;
    logic             o_instr_valid;
    logic             o_halted;
    logic [1:0]       o_state;

    // Side that issues requests and consumes the PC (debug unit, memory, bench)
    modport master (
        output i_run, i_step, i_restart, i_stall,
        output i_branch, i_branch_target, i_jump, i_jump_target,
        output i_instruction,
        input  o_pc, o_pc_plus4, o_instr_valid, o_halted, o_state
    );

    // Fetch PC controller side
    modport slave (
        input  i_run, i_step, i_restart, i_stall,
        input  i_branch, i_branch_target, i_jump, i_jump_target,
        input  i_instruction,
        output o_pc, o_pc_plus4, o_instr_valid, o_halted, o_state
    );
endinterface

// File: rtl/fetch_pc_control_pc_next_sel.sv
// Combinational next-PC selection for a fetch cycle:
// branch > stall (hold) > jump > sequential PC+4.
module pc_next_sel
    import fetch_pc_control_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] pc_i,
    input  logic             branch_i,
    input  logic [NBITS-1:0] branch_target_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic [NBITS-1:0] jump_target_i,
    output logic [NBITS-1:0] pc_next_o,
    output logic [NBITS-1:0] pc_plus4_o
);

    // Word alignment mask: redirect targets always land on a word boundary
    localparam logic [NBITS-1:0] ALIGN_MASK = ~NBITS'(3);

    // Sequential address, wrapping naturally modulo 2^NBITS
    assign pc_plus4_o = pc_i + NBITS'(PC_INC);

    // Priority mux; a taken branch overrides even a stall
    always_comb begin
        pc_next_o = pc_plus4_o;
        if (branch_i) begin
            pc_next_o = branch_target_i & ALIGN_MASK;
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end else if (jump_i) begin
            pc_next_o = jump_target_i & ALIGN_MASK;
        end
    end

endmodule

// File: rtl/fetch_pc_control.sv
// Fetch PC controller: IDLE/RUN/STEP/HALT FSM driven by the debug unit,
// PC register with redirect handling, and halt-word detection on the
// word returned by instruction memory.
module fetch_pc_control
    import fetch_pc_control_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter logic [NBITS-1:0] PC_RESET  = '0,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEF)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    fetch_pc_control_if.slave   bus
);

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] pc_plus4_q, pc_plus4_d;
    logic             valid_q, valid_d;

    logic [NBITS-1:0] pc_next;
    logic [NBITS-1:0] pc_seq;
    logic             fetch_cycle;
    logic             halt_hit;

    pc_next_sel #(
        .NBITS(NBITS)
    ) u_pc_next_sel (
        .pc_i            (pc_q),
        .branch_i        (bus.i_branch),
        .branch_target_i (bus.i_branch_target),
        .stall_i         (bus.i_stall),
        .jump_i          (bus.i_jump),
        .jump_target_i   (bus.i_jump_target),
        .pc_next_o       (pc_next),
        .pc_plus4_o      (pc_seq)
    );

    assign fetch_cycle = is_fetch_state(state_q);

    // The word on i_instruction is only meaningful while valid is set
    assign halt_hit = valid_q && (bus.i_instruction == HALT_WORD) && (state_q != ST_HALT);

    // Next-state logic: restart beats everything, HALT freezes, a halt word
    // beats the fetch that would otherwise retire this edge
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = 1'b0;
        if (bus.i_restart) begin
            state_d = ST_IDLE;
            pc_d    = PC_RESET;
        end else if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (halt_hit) begin
            // The fetch already in flight behind the halt word is dropped
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_run) begin
                        state_d = ST_RUN;
                    end else if (bus.i_step) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
            if (fetch_cycle) begin
                pc_d       = pc_next;
                pc_plus4_d = pc_seq;
                valid_d    = 1'b1;
            end
        end
    end

    // State and PC registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_RESET;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_pc_plus4    = pc_plus4_q;
    assign bus.o_instr_valid = valid_q;
    assign bus.o_halted      = (state_q == ST_HALT);
    assign bus.o_state       = state_q;

endmodule
